// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared memory bus seen by mem_bus_arbiter.
// The master modport is the arbiter; the slave modport is the pipeline/memory side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  inst_ok;

    logic                  data_req;
    logic [DATA_W/8-1:0]   data_wen;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_ok;

    logic                  mem_req;
    logic                  mem_wr;
    logic [DATA_W/8-1:0]   mem_wen;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_addr_ok;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_data_ok;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_wen, data_addr, data_wdata,
        input  mem_addr_ok, mem_rdata, mem_data_ok,
        output inst_rdata, inst_ok, data_rdata, data_ok,
        output mem_req, mem_wr, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_wen, data_addr, data_wdata,
        output mem_addr_ok, mem_rdata, mem_data_ok,
        input  inst_rdata, inst_ok, data_rdata, data_ok,
        input  mem_req, mem_wr, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and data ports, one transaction in flight.
// Data wins arbitration unless it has already taken STARVE_LIMIT grants while fetch waited.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.master  bus,
    output logic               busy
);
    localparam int WEN_W = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t            state, stateNext;
    owner_t            owner;
    logic [CNT_W-1:0]  streak;
    logic [ADDR_W-1:0] memAddr;
    logic [WEN_W-1:0]  memWen;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] instRdata;
    logic [DATA_W-1:0] dataRdata;
    logic              grantData;
    logic              grantInst;
    logic              capture;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Requests are only looked at in IDLE; bus strobes only in ADDR/DATA.
    always_comb begin
        stateNext = state;
        grantData = 1'b0;
        grantInst = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.data_req && (!bus.inst_req || streak < LIMIT)) grantData = 1'b1;
                else if (bus.inst_req)                                 grantInst = 1'b1;
                if (grantData || grantInst) stateNext = ADDR;
            end
            ADDR: begin
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        stateNext = RESP;
                        capture   = 1'b1;
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (bus.mem_data_ok) begin
                    stateNext = RESP;
                    capture   = 1'b1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_INST;
            streak    <= '0;
            memAddr   <= '0;
            memWen    <= '0;
            memWdata  <= '0;
            instRdata <= '0;
            dataRdata <= '0;
        end else begin
            if (grantData) begin
                owner    <= OWN_DATA;
                memAddr  <= bus.data_addr;
                memWen   <= bus.data_wen;
                memWdata <= bus.data_wdata;
                // Only data grants taken over a waiting fetch count toward starvation.
                if (bus.inst_req) streak <= (streak == LIMIT) ? streak : streak + 1'b1;
                else              streak <= '0;
            end else if (grantInst) begin
                owner    <= OWN_INST;
                memAddr  <= bus.inst_addr;
                memWen   <= '0;
                memWdata <= '0;
                streak   <= '0;
            end
            // Stores leave the owner's read-data register untouched.
            if (capture && memWen == '0) begin
                if (owner == OWN_DATA) dataRdata <= bus.mem_rdata;
                else                   instRdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req    = (state == ADDR);
    assign bus.mem_wr     = |memWen;
    assign bus.mem_wen    = memWen;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;
    assign bus.inst_ok    = (state == RESP) && (owner == OWN_INST);
    assign bus.data_ok    = (state == RESP) && (owner == OWN_DATA);
    assign bus.inst_rdata = instRdata;
    assign bus.data_rdata = dataRdata;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboarded bench for mem_bus_arbiter: a reactive memory model plus per-scenario tasks.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;
    localparam logic [10:0] SEQ_EXP = 11'b10111101111;  // bit i = 1 when grant i went to data

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy)
    );

    int nChecks = 0;
    int nPass   = 0;
    logic [31:0] expInstQ[$];
    logic [31:0] expDataQ[$];
    logic [31:0] lastInstExp = '0;
    logic [31:0] lastDataExp = '0;

    // Memory model: addrDelay idle ADDR cycles before addr_ok, data_ok dataDelay cycles later.
    logic        busEn = 1'b0;
    int          addrDelay = 0;
    int          dataDelay = 0;
    logic        mAddrOk = 1'b0, mDataOk = 1'b0, pend = 1'b0;
    logic [31:0] mRdata = '0, respVal = '0;
    int          aCnt = 0, dCnt = 0;
    logic        manAddrOk = 1'b0, manDataOk = 1'b0;
    logic [31:0] manRdata = '0;

    assign bus.mem_addr_ok = busEn ? mAddrOk : manAddrOk;
    assign bus.mem_data_ok = busEn ? mDataOk : manDataOk;
    assign bus.mem_rdata   = busEn ? mRdata  : manRdata;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h24080001;
        return {a[15:0], ~a[15:0]} ^ 32'h13570000;
    endfunction

    always @(negedge clk) begin
        mAddrOk <= 1'b0;
        mDataOk <= 1'b0;
        if (rst || !busEn) begin
            pend <= 1'b0;
            aCnt <= 0;
        end else if (pend) begin
            if (dCnt + 1 >= dataDelay) begin
                mDataOk <= 1'b1;
                mRdata  <= respVal;
                pend    <= 1'b0;
            end
            dCnt <= dCnt + 1;
        end else if (bus.mem_req) begin
            if (aCnt >= addrDelay) begin
                mAddrOk <= 1'b1;
                aCnt    <= 0;
                if (dataDelay == 0) begin
                    mDataOk <= 1'b1;
                    mRdata  <= bus.mem_wr ? 32'hBAD0BAD0 : memWord(bus.mem_addr);
                end else begin
                    pend    <= 1'b1;
                    dCnt    <= 0;
                    respVal <= bus.mem_wr ? 32'hBAD0BAD0 : memWord(bus.mem_addr);
                end
            end else begin
                aCnt <= aCnt + 1;
            end
        end
    end

    int okCnt = 0;
    int overlapCnt = 0;
    always @(negedge clk) begin
        if (bus.inst_ok && bus.data_ok) overlapCnt <= overlapCnt + 1;
        okCnt <= okCnt + int'(bus.inst_ok) + int'(bus.data_ok);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.inst_req = 1'b0; bus.inst_addr = '0;
        bus.data_req = 1'b0; bus.data_wen = '0; bus.data_addr = '0; bus.data_wdata = '0;
        rst = 1'b1;
        repeat (3) tick();
        nChecks++; if ({bus.mem_req, bus.mem_wr, bus.inst_ok, bus.data_ok, busy} !== 5'b0)
            $display("FAIL rst_ctrl got=%b exp=00000", {bus.mem_req, bus.mem_wr, bus.inst_ok, bus.data_ok, busy}); else nPass++;
        nChecks++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); else nPass++;
        nChecks++; if ({bus.mem_wen, bus.mem_wdata} !== 36'h0) $display("FAIL rst_wen_wdata got=%h exp=0", {bus.mem_wen, bus.mem_wdata}); else nPass++;
        nChecks++; if (bus.inst_rdata !== 32'h0) $display("FAIL rst_inst_rdata got=%h exp=0", bus.inst_rdata); else nPass++;
        nChecks++; if (bus.data_rdata !== 32'h0) $display("FAIL rst_data_rdata got=%h exp=0", bus.data_rdata); else nPass++;
        nChecks++; if (dut.streak !== 3'd0) $display("FAIL rst_streak got=%0d exp=0", dut.streak); else nPass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        logic [31:0] e;
        busEn = 1'b1; addrDelay = 0; dataDelay = 0;
        bus.inst_addr = 32'hBFC00000; bus.inst_req = 1'b1;
        expInstQ.push_back(memWord(32'hBFC00000));
        lastInstExp = memWord(32'hBFC00000);
        tick();
        nChecks++; if (bus.mem_req !== 1'b1) $display("FAIL t1_mem_req got=%b exp=1", bus.mem_req); else nPass++;
        nChecks++; if (bus.mem_addr !== 32'hBFC00000) $display("FAIL t1_mem_addr got=%h exp=bfc00000", bus.mem_addr); else nPass++;
        nChecks++; if ({bus.mem_wr, bus.mem_wen} !== 5'b0) $display("FAIL t1_mem_wr got=%b exp=0", {bus.mem_wr, bus.mem_wen}); else nPass++;
        nChecks++; if (bus.inst_ok !== 1'b0) $display("FAIL t1_ok_early got=%b exp=0", bus.inst_ok); else nPass++;
        tick();
        nChecks++; if ({bus.inst_ok, bus.data_ok} !== 2'b10) $display("FAIL t1_ok_latency got=%b exp=10", {bus.inst_ok, bus.data_ok}); else nPass++;
        if (bus.inst_ok) begin
            nChecks++;
            if (expInstQ.size() == 0) $display("FAIL t1_sb_inst got=%h exp=none", bus.inst_rdata);
            else begin e = expInstQ.pop_front(); if (bus.inst_rdata !== e) $display("FAIL t1_sb_inst got=%h exp=%h", bus.inst_rdata, e); else nPass++; end
        end
        bus.inst_req = 1'b0;
        tick();
        nChecks++; if ({bus.inst_ok, busy} !== 2'b00) $display("FAIL t1_one_pulse got=%b exp=00", {bus.inst_ok, busy}); else nPass++;
        nChecks++; if (expInstQ.size() !== 0) $display("FAIL t1_sb_pending got=%0d exp=0", expInstQ.size()); else nPass++;
    endtask

    task automatic test_priority();
        logic [31:0] e;
        logic [31:0] firstAddr = '0;
        logic        gotGrant = 1'b0;
        int          dOkCyc = -1, iOkCyc = -1;
        bus.inst_addr = 32'hBFC00010; bus.data_addr = 32'h80000020; bus.data_wen = '0;
        expInstQ.push_back(memWord(32'hBFC00010)); lastInstExp = memWord(32'hBFC00010);
        expDataQ.push_back(memWord(32'h80000020)); lastDataExp = memWord(32'h80000020);
        bus.inst_req = 1'b1; bus.data_req = 1'b1;
        for (int c = 0; c < 40 && (bus.inst_req || bus.data_req || busy); c++) begin
            tick();
            if (bus.mem_req && !gotGrant) begin firstAddr = bus.mem_addr; gotGrant = 1'b1; end
            if (bus.data_ok) begin
                dOkCyc = c; bus.data_req = 1'b0; nChecks++;
                if (expDataQ.size() == 0) $display("FAIL t2_sb_data got=%h exp=none", bus.data_rdata);
                else begin e = expDataQ.pop_front(); if (bus.data_rdata !== e) $display("FAIL t2_sb_data got=%h exp=%h", bus.data_rdata, e); else nPass++; end
            end
            if (bus.inst_ok) begin
                iOkCyc = c; bus.inst_req = 1'b0; nChecks++;
                if (expInstQ.size() == 0) $display("FAIL t2_sb_inst got=%h exp=none", bus.inst_rdata);
                else begin e = expInstQ.pop_front(); if (bus.inst_rdata !== e) $display("FAIL t2_sb_inst got=%h exp=%h", bus.inst_rdata, e); else nPass++; end
            end
        end
        nChecks++; if (firstAddr !== 32'h80000020) $display("FAIL t2_first_grant got=%h exp=80000020", firstAddr); else nPass++;
        nChecks++; if (!(dOkCyc >= 0 && iOkCyc > dOkCyc)) $display("FAIL t2_order got=data@%0d,inst@%0d exp=data_first", dOkCyc, iOkCyc); else nPass++;
        nChecks++; if (expInstQ.size() + expDataQ.size() !== 0) $display("FAIL t2_sb_pending got=%0d exp=0", expInstQ.size() + expDataQ.size()); else nPass++;
    endtask

    task automatic test_starve();
        logic [31:0] e;
        logic [31:0] dAddr = 32'h80000100, iAddr = 32'hBFC00100;
        logic [10:0] got = '0;
        logic        prevReq = 1'b0, isD;
        int          grants = 0, sModel = 0;
        bus.data_wen = '0; bus.data_addr = dAddr; bus.inst_addr = iAddr;
        expDataQ.push_back(memWord(dAddr)); lastDataExp = memWord(dAddr);
        expInstQ.push_back(memWord(iAddr)); lastInstExp = memWord(iAddr);
        bus.data_req = 1'b1; bus.inst_req = 1'b1;
        for (int c = 0; c < 200 && (bus.inst_req || bus.data_req || busy); c++) begin
            tick();
            if (bus.mem_req && !prevReq) begin
                isD = (bus.mem_addr[31:28] == 4'h8);
                if (grants < 11) got[grants] = isD;
                grants++;
                if (isD && bus.inst_req) sModel = (sModel < LIMIT) ? sModel + 1 : sModel;
                else                     sModel = 0;
                nChecks++; if (dut.streak !== 3'(sModel)) $display("FAIL t3_streak_g%0d got=%0d exp=%0d", grants, dut.streak, sModel); else nPass++;
            end
            prevReq = bus.mem_req;
            if (bus.data_ok) begin
                nChecks++;
                if (expDataQ.size() == 0) $display("FAIL t3_sb_data got=%h exp=none", bus.data_rdata);
                else begin e = expDataQ.pop_front(); if (bus.data_rdata !== e) $display("FAIL t3_sb_data got=%h exp=%h", bus.data_rdata, e); else nPass++; end
                if (grants >= 10) bus.data_req = 1'b0;
                else begin dAddr += 32'd4; bus.data_addr = dAddr; expDataQ.push_back(memWord(dAddr)); lastDataExp = memWord(dAddr); end
            end
            if (bus.inst_ok) begin
                nChecks++;
                if (expInstQ.size() == 0) $display("FAIL t3_sb_inst got=%h exp=none", bus.inst_rdata);
                else begin e = expInstQ.pop_front(); if (bus.inst_rdata !== e) $display("FAIL t3_sb_inst got=%h exp=%h", bus.inst_rdata, e); else nPass++; end
                if (grants >= 10) bus.inst_req = 1'b0;
                else begin iAddr += 32'd4; bus.inst_addr = iAddr; expInstQ.push_back(memWord(iAddr)); lastInstExp = memWord(iAddr); end
            end
        end
        nChecks++; if (grants !== 11) $display("FAIL t3_grant_count got=%0d exp=11", grants); else nPass++;
        nChecks++; if (got !== SEQ_EXP) $display("FAIL t3_grant_seq got=%b exp=%b", got, SEQ_EXP); else nPass++;
        nChecks++; if (expInstQ.size() + expDataQ.size() !== 0) $display("FAIL t3_sb_pending got=%0d exp=0", expInstQ.size() + expDataQ.size()); else nPass++;
    endtask

    task automatic test_store();
        logic [31:0] e;
        logic        stable = 1'b1;
        int          reqCycles = 0, okPulses = 0;
        addrDelay = 3; dataDelay = 2;
        bus.data_wen = 4'b0011; bus.data_addr = 32'h80001004; bus.data_wdata = 32'hDEADBEEF;
        expDataQ.push_back(lastDataExp);
        bus.data_req = 1'b1;
        for (int c = 0; c < 40 && (bus.data_req || busy); c++) begin
            tick();
            if (bus.mem_req) begin
                reqCycles++;
                if (bus.mem_addr !== 32'h80001004 || bus.mem_wen !== 4'b0011 ||
                    bus.mem_wdata !== 32'hDEADBEEF || bus.mem_wr !== 1'b1) stable = 1'b0;
            end
            if (bus.data_ok) begin
                okPulses++; bus.data_req = 1'b0; nChecks++;
                if (expDataQ.size() == 0) $display("FAIL t4_sb_data got=%h exp=none", bus.data_rdata);
                else begin e = expDataQ.pop_front(); if (bus.data_rdata !== e) $display("FAIL t4_sb_data got=%h exp=%h", bus.data_rdata, e); else nPass++; end
            end
        end
        nChecks++; if (stable !== 1'b1) $display("FAIL t4_addr_hold got=%b exp=1", stable); else nPass++;
        nChecks++; if (reqCycles !== 4) $display("FAIL t4_req_cycles got=%0d exp=4", reqCycles); else nPass++;
        nChecks++; if (okPulses !== 1) $display("FAIL t4_ok_pulses got=%0d exp=1", okPulses); else nPass++;
        nChecks++; if ({bus.mem_wr, bus.mem_wen} !== 5'b10011) $display("FAIL t4_mem_wen got=%b exp=10011", {bus.mem_wr, bus.mem_wen}); else nPass++;
        nChecks++; if (expDataQ.size() !== 0) $display("FAIL t4_sb_pending got=%0d exp=0", expDataQ.size()); else nPass++;
        bus.data_wen = '0; bus.data_wdata = '0; addrDelay = 0; dataDelay = 0;
    endtask

    task automatic test_stray();
        logic [1:0] strobes [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
        logic       leftIdle = 1'b0;
        int         okBefore = okCnt;
        busEn = 1'b0; manRdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            {manAddrOk, manDataOk} = strobes[i];
            tick();
            if (busy || bus.mem_req) leftIdle = 1'b1;
        end
        {manAddrOk, manDataOk} = 2'b00;
        tick();
        nChecks++; if (leftIdle !== 1'b0) $display("FAIL t6_state got=busy exp=idle"); else nPass++;
        nChecks++; if (okCnt !== okBefore) $display("FAIL t6_ok_pulses got=%0d exp=0", okCnt - okBefore); else nPass++;
        nChecks++; if (bus.inst_rdata !== lastInstExp) $display("FAIL t6_inst_rdata got=%h exp=%h", bus.inst_rdata, lastInstExp); else nPass++;
        nChecks++; if (bus.data_rdata !== lastDataExp) $display("FAIL t6_data_rdata got=%h exp=%h", bus.data_rdata, lastDataExp); else nPass++;
    endtask

    task automatic test_reset_mid();
        int okBefore;
        busEn = 1'b0;
        bus.data_wen = '0; bus.data_addr = 32'h80000040; bus.data_req = 1'b1;
        tick();
        nChecks++; if (bus.mem_req !== 1'b1) $display("FAIL t5_addr_phase got=%b exp=1", bus.mem_req); else nPass++;
        manAddrOk = 1'b1;
        tick();
        manAddrOk = 1'b0;
        nChecks++; if ({busy, bus.mem_req} !== 2'b10) $display("FAIL t5_data_phase got=%b exp=10", {busy, bus.mem_req}); else nPass++;
        okBefore = okCnt;
        rst = 1'b1; bus.data_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        manDataOk = 1'b1; manRdata = 32'h12345678;
        tick();
        manDataOk = 1'b0;
        repeat (2) tick();
        nChecks++; if (okCnt !== okBefore) $display("FAIL t5_ok_pulses got=%0d exp=0", okCnt - okBefore); else nPass++;
        nChecks++; if ({busy, bus.mem_req} !== 2'b00) $display("FAIL t5_idle got=%b exp=00", {busy, bus.mem_req}); else nPass++;
        nChecks++; if (bus.inst_rdata !== 32'h0) $display("FAIL t5_inst_rdata got=%h exp=0", bus.inst_rdata); else nPass++;
        nChecks++; if (bus.data_rdata !== 32'h0) $display("FAIL t5_data_rdata got=%h exp=0", bus.data_rdata); else nPass++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_starve();
        test_store();
        test_stray();
        test_reset_mid();
        nChecks++; if (overlapCnt !== 0) $display("FAIL ok_overlap got=%0d exp=0", overlapCnt); else nPass++;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
